// File: rtl/inst_fetcher_pkg.sv
// Shared constants and helpers for the instruction fetch stage: field positions,
// widths, FSM state type, immediate decoders and the BHT counter update.
package inst_fetcher_pkg;

  localparam int ADDR_WID = 32;
  localparam int INST_WID = 32;
  localparam int DATA_WID = 32;

  localparam int OPCODE_LO = 0;
  localparam int OPCODE_HI = 6;
  localparam int RD_LO     = 7;
  localparam int RD_HI     = 11;
  localparam int RS1_LO    = 15;
  localparam int RS1_HI    = 19;
  localparam int RS2_LO    = 20;
  localparam int RS2_HI    = 24;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;
  localparam logic [6:0] OPCODE_B   = 7'b1100011;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } fetch_state_e;

  function automatic logic [ADDR_WID-1:0] imm_j(input logic [INST_WID-1:0] i);
    imm_j = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [ADDR_WID-1:0] imm_b(input logic [INST_WID-1:0] i);
    imm_b = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  // Two-bit saturating counter step.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      ctr_update = (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
    end else begin
      ctr_update = (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
    end
  endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Fetch-stage bus: control inputs, memory-controller miss port, decode handshake
// and branch-update port. master = fetcher side, slave = environment side.
interface inst_fetcher_if;
  import inst_fetcher_pkg::*;

  logic                rdy;
  logic                stall;
  logic                rollback;
  logic [ADDR_WID-1:0] rollback_pc;
  logic                mc_req;
  logic [ADDR_WID-1:0] mc_addr;
  logic                mc_done;
  logic [DATA_WID-1:0] mc_data;
  logic                inst_rdy;
  logic [INST_WID-1:0] inst;
  logic [ADDR_WID-1:0] inst_pc;
  logic                inst_pre_jump;
  logic                br_upd;
  logic [ADDR_WID-1:0] br_upd_pc;
  logic                br_upd_taken;

  modport master (
    input  rdy, stall, rollback, rollback_pc, mc_done, mc_data,
           br_upd, br_upd_pc, br_upd_taken,
    output mc_req, mc_addr, inst_rdy, inst, inst_pc, inst_pre_jump
  );

  modport slave (
    output rdy, stall, rollback, rollback_pc, mc_done, mc_data,
           br_upd, br_upd_pc, br_upd_taken,
    input  mc_req, mc_addr, inst_rdy, inst, inst_pc, inst_pre_jump
  );

endinterface

// File: rtl/inst_fetcher_branch_predictor.sv
// Branch history table of 2-bit saturating counters; combinational lookup,
// synchronous update. A same-cycle lookup of the updated entry sees the old value.
module inst_fetcher_branch_predictor
  import inst_fetcher_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy_i,
  input  logic [IDX_W-1:0] lookup_idx_i,
  output logic             taken_o,
  input  logic             upd_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0] bht_q [ENTRIES];

  assign taken_o = bht_q[lookup_idx_i][1];

  // Counter table: weakly-not-taken after reset, frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (rdy_i && upd_i) begin
      bht_q[upd_idx_i] <= ctr_update(bht_q[upd_idx_i], upd_taken_i);
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: PC, direct-mapped icache, miss requests, next-PC prediction.
// Define IFETCH_BHT_EN to enable the BHT for conditional branches (otherwise not-taken).
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int ICACHE_IDX_W = 8,
  parameter int BHT_IDX_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  inst_fetcher_if.master bus
);

  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = ADDR_WID - ICACHE_IDX_W - 2;

  fetch_state_e        state_q;
  logic [ADDR_WID-1:0] pc_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_mem_q  [LINES];
  logic [INST_WID-1:0] data_mem_q [LINES];

  logic                mc_req_q;
  logic [ADDR_WID-1:0] mc_addr_q;
  logic                inst_rdy_q;
  logic [INST_WID-1:0] inst_q;
  logic [ADDR_WID-1:0] inst_pc_q;
  logic                inst_pre_jump_q;

  logic [ICACHE_IDX_W-1:0] fetch_idx_s;
  logic [TAG_W-1:0]        fetch_tag_s;
  logic [ICACHE_IDX_W-1:0] fill_idx_s;
  logic [TAG_W-1:0]        fill_tag_s;
  logic [INST_WID-1:0]     line_s;
  logic                    hit_s;
  logic                    fill_we_s;
  logic                    bht_taken_s;
  logic [6:0]              opcode_s;
  logic [ADDR_WID-1:0]     next_pc_d;
  logic                    pred_d;

  assign fetch_idx_s = pc_q[ICACHE_IDX_W+1:2];
  assign fetch_tag_s = pc_q[ADDR_WID-1:ICACHE_IDX_W+2];
  assign fill_idx_s  = mc_addr_q[ICACHE_IDX_W+1:2];
  assign fill_tag_s  = mc_addr_q[ADDR_WID-1:ICACHE_IDX_W+2];
  assign line_s      = data_mem_q[fetch_idx_s];
  assign hit_s       = valid_q[fetch_idx_s] && (tag_mem_q[fetch_idx_s] == fetch_tag_s);
  assign opcode_s    = line_s[OPCODE_HI:OPCODE_LO];

  // A fill only lands when the FSM would actually accept it, so aborted misses never write.
  assign fill_we_s = rst && bus.rdy && !bus.rollback && (state_q == S_WAIT_MEM) && bus.mc_done;

`ifdef IFETCH_BHT_EN
  inst_fetcher_branch_predictor #(
    .IDX_W (BHT_IDX_W)
  ) u_branch_predictor (
    .clk          (clk),
    .rst          (rst),
    .rdy_i        (bus.rdy),
    .lookup_idx_i (pc_q[BHT_IDX_W+1:2]),
    .taken_o      (bht_taken_s),
    .upd_i        (bus.br_upd),
    .upd_idx_i    (bus.br_upd_pc[BHT_IDX_W+1:2]),
    .upd_taken_i  (bus.br_upd_taken)
  );
`else
  logic unused_br_upd_s;
  assign unused_br_upd_s = ^{bus.br_upd, bus.br_upd_pc, bus.br_upd_taken};
  assign bht_taken_s     = 1'b0;
`endif

  // Next-PC prediction from the instruction at the current PC.
  always_comb begin
    next_pc_d = pc_q + 32'd4;
    pred_d    = 1'b0;
    case (opcode_s)
      OPCODE_JAL: begin
        next_pc_d = pc_q + imm_j(line_s);
        pred_d    = 1'b1;
      end
      OPCODE_B: begin
        if (bht_taken_s) begin
          next_pc_d = pc_q + imm_b(line_s);
          pred_d    = 1'b1;
        end else begin
          next_pc_d = pc_q + 32'd4;
          pred_d    = 1'b0;
        end
      end
      default: begin
        next_pc_d = pc_q + 32'd4;
        pred_d    = 1'b0;
      end
    endcase
  end

  // Fetch FSM: rollback beats miss completion, which beats a new fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      pc_q            <= '0;
      valid_q         <= '0;
      mc_req_q        <= 1'b0;
      mc_addr_q       <= '0;
      inst_rdy_q      <= 1'b0;
      inst_q          <= '0;
      inst_pc_q       <= '0;
      inst_pre_jump_q <= 1'b0;
    end else if (bus.rdy) begin
      inst_rdy_q <= 1'b0;
      if (bus.rollback) begin
        pc_q     <= bus.rollback_pc;
        mc_req_q <= 1'b0;
        state_q  <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!hit_s) begin
              mc_req_q  <= 1'b1;
              mc_addr_q <= pc_q;
              state_q   <= S_WAIT_MEM;
            end else if (!bus.stall) begin
              inst_rdy_q      <= 1'b1;
              inst_q          <= line_s;
              inst_pc_q       <= pc_q;
              inst_pre_jump_q <= pred_d;
              pc_q            <= next_pc_d;
            end
          end
          S_WAIT_MEM: begin
            if (bus.mc_done) begin
              valid_q[fill_idx_s] <= 1'b1;
              mc_req_q            <= 1'b0;
              state_q             <= S_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Icache tag/data arrays; contents are qualified by valid_q so they need no reset.
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      tag_mem_q[fill_idx_s]  <= fill_tag_s;
      data_mem_q[fill_idx_s] <= bus.mc_data;
    end
  end

  assign bus.mc_req        = mc_req_q;
  assign bus.mc_addr       = mc_addr_q;
  assign bus.inst_rdy      = inst_rdy_q;
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.inst_pre_jump = inst_pre_jump_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: expected decode-side outputs are queued by the
// stimulus and checked by an independent monitor. Honours IFETCH_BHT_EN.
module tb_inst_fetcher;

  logic clk = 1'b0;
  logic rst;

  inst_fetcher_if bus ();

  inst_fetcher dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pre;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef IFETCH_BHT_EN
  localparam bit BR_PRED = 1'b1;
`else
  localparam bit BR_PRED = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JAL = 32'h0080_006F;
  localparam logic [31:0] BEQ = 32'h0000_0863;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every emitted instruction must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.inst_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst: got pc %h inst %h want no output", bus.inst_pc, bus.inst);
      end else begin
        e = exp_q.pop_front();
        check1("inst", bus.inst, e.inst);
        check1("inst_pc", bus.inst_pc, e.pc);
        check1("inst_pre_jump", {31'd0, bus.inst_pre_jump}, {31'd0, e.pre});
      end
    end
  end

  task automatic wait_req(input logic [31:0] addr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mc_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL mc_req_timeout: got mc_req 0 want 1 for addr %h", addr);
    end else begin
      check1("mc_addr", bus.mc_addr, addr);
    end
  endtask

  task automatic serve(input logic [31:0] addr, input logic [31:0] data, input logic pre);
    bit ok;
    wait_req(addr, ok);
    if (ok) begin
      exp_q.push_back('{inst: data, pc: addr, pre: pre});
      bus.mc_done = 1'b1;
      bus.mc_data = data;
      @(negedge clk);
      bus.mc_done = 1'b0;
      bus.mc_data = 32'd0;
    end
  endtask

  initial begin
    bit          ok;
    logic [31:0] tgt;
    tgt = BR_PRED ? 32'h0000_0020 : 32'h0000_0014;

    rst              = 1'b0;
    bus.rdy          = 1'b1;
    bus.stall        = 1'b0;
    bus.rollback     = 1'b0;
    bus.rollback_pc  = 32'd0;
    bus.mc_done      = 1'b0;
    bus.mc_data      = 32'd0;
    bus.br_upd       = 1'b0;
    bus.br_upd_pc    = 32'd0;
    bus.br_upd_taken = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check1("rst_inst_rdy", {31'd0, bus.inst_rdy}, 32'd0);
    check1("rst_mc_req", {31'd0, bus.mc_req}, 32'd0);
    check1("rst_mc_addr", bus.mc_addr, 32'd0);
    check1("rst_inst_pc", bus.inst_pc, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check1("first_mc_req", {31'd0, bus.mc_req}, 32'd1);
    check1("first_mc_addr", bus.mc_addr, 32'd0);

    // Miss fill then sequential and JAL-redirected fetches
    serve(32'h0000_0000, NOP, 1'b0);
    serve(32'h0000_0004, JAL, 1'b1);
    serve(32'h0000_000C, NOP, 1'b0);

    // Rollback while waiting on memory; the late fill must be dropped
    wait_req(32'h0000_0010, ok);
    bus.rollback    = 1'b1;
    bus.rollback_pc = 32'h0000_0100;
    @(negedge clk);
    bus.rollback = 1'b0;
    check1("rollback_drops_req", {31'd0, bus.mc_req}, 32'd0);
    bus.mc_done = 1'b1;
    bus.mc_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mc_done = 1'b0;
    bus.mc_data = 32'd0;
    check1("redirect_mc_req", {31'd0, bus.mc_req}, 32'd1);
    check1("redirect_mc_addr", bus.mc_addr, 32'h0000_0100);
    serve(32'h0000_0100, NOP, 1'b0);

    // Train the BHT for 0x10 taken twice, then redirect there
    wait_req(32'h0000_0104, ok);
    bus.br_upd       = 1'b1;
    bus.br_upd_pc    = 32'h0000_0010;
    bus.br_upd_taken = 1'b1;
    repeat (2) @(negedge clk);
    bus.br_upd       = 1'b0;
    bus.rollback     = 1'b1;
    bus.rollback_pc  = 32'h0000_0010;
    @(negedge clk);
    bus.rollback = 1'b0;
    serve(32'h0000_0010, BEQ, BR_PRED);
    serve(tgt, NOP, 1'b0);
    repeat (3) @(negedge clk);

    // Stall on a cached line holds the PC, then back-to-back hits on release
    bus.stall       = 1'b1;
    bus.rollback    = 1'b1;
    bus.rollback_pc = 32'h0000_0010;
    @(negedge clk);
    bus.rollback = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check1("stall_inst_rdy", {31'd0, bus.inst_rdy}, 32'd0);
      check1("stall_mc_req", {31'd0, bus.mc_req}, 32'd0);
    end
    bus.stall = 1'b0;
    exp_q.push_back('{inst: BEQ, pc: 32'h0000_0010, pre: BR_PRED});
    exp_q.push_back('{inst: NOP, pc: tgt, pre: 1'b0});
    @(negedge clk);
    check1("unstall_hit0", {31'd0, bus.inst_rdy}, 32'd1);
    @(negedge clk);
    check1("unstall_hit1", {31'd0, bus.inst_rdy}, 32'd1);
    wait_req(tgt + 32'd4, ok);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check1("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
